// File: rtl/key_expand.sv
// key_expand: byte-serial AES-128 key schedule.
// Loads a 16-byte cipher key (FIPS-197 byte order, byte 0 first) and then
// computes each successive round key in place when round_next is pulsed.
// The current round key can be read one byte at a time through byte_sel.
// Optional build macro KEY_EXPAND_REWIND_EN adds a shadow copy of the loaded
// key and the round_rewind input, which restores round 0 in a single cycle.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   key_load     pulse: abort any activity and start a key load
//   key_in       key byte, byte 0 first
//   key_in_valid key_in is valid this cycle (used in LOAD only)
//   round_next   pulse: compute the next round key
//   byte_sel     round-key byte index 0..15
//   subkey       rk[byte_sel], combinational
//   round_num    index of the round key currently held
//   key_ready    round key valid and stable
//   busy         next round key being computed
//   last_round   round_num == NUM_ROUNDS and key_ready
//   round_rewind (KEY_EXPAND_REWIND_EN only) return to round 0 from READY
module key_expand #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       key_load,
    input  logic [7:0] key_in,
    input  logic       key_in_valid,
    input  logic       round_next,
    input  logic [3:0] byte_sel,
`ifdef KEY_EXPAND_REWIND_EN
    input  logic       round_rewind,
`endif
    output logic [7:0] subkey,
    output logic [3:0] round_num,
    output logic       key_ready,
    output logic       busy,
    output logic       last_round
);

    typedef enum logic [2:0] {IDLE, LOAD, SUBW, XORW, READY} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [7:0] rk_q     [16];
    logic [7:0] rk_d     [16];
    logic [7:0] temp_q   [4];
    logic [7:0] temp_d   [4];
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q,  rcon_d;
`ifdef KEY_EXPAND_REWIND_EN
    logic [7:0] shadow_q [16];
    logic [7:0] shadow_d [16];
`endif

    // RotWord: temp[i] takes byte (i+1) mod 4 of the last word (bytes 12..15).
    logic [1:0] rot_idx;
    logic [7:0] sbox_out;
    assign rot_idx  = cnt_q[1:0] + 2'd1;
    assign sbox_out = SBOX[rk_q[{2'b11, rot_idx}]];

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        temp_d  = temp_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        rcon_d  = rcon_q;
`ifdef KEY_EXPAND_REWIND_EN
        shadow_d = shadow_q;
`endif
        if (key_load) begin
            state_d = LOAD;
            cnt_d   = '0;
            round_d = '0;
            rcon_d  = 8'h01;
        end else begin
            case (state_q)
                LOAD: begin
                    if (key_in_valid) begin
                        rk_d[cnt_q] = key_in;
`ifdef KEY_EXPAND_REWIND_EN
                        shadow_d[cnt_q] = key_in;
`endif
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_d = READY;
                            round_d = '0;
                            rcon_d  = 8'h01;
                        end
                    end
                end
                READY: begin
`ifdef KEY_EXPAND_REWIND_EN
                    if (round_rewind) begin
                        rk_d    = shadow_q;
                        round_d = '0;
                        rcon_d  = 8'h01;
                    end else
`endif
                    if (round_next && (round_q < LAST_RND)) begin
                        state_d = SUBW;
                        cnt_d   = '0;
                    end
                end
                SUBW: begin
                    temp_d[cnt_q[1:0]] = sbox_out ^ ((cnt_q[1:0] == 2'd0) ? rcon_q : 8'h00);
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = XORW;
                        cnt_d   = '0;
                    end
                end
                XORW: begin
                    // rk[j-4] was rewritten four cycles earlier, so reading rk_q
                    // here already yields the new word needed by the chain.
                    rk_d[cnt_q] = rk_q[cnt_q] ^
                                  ((cnt_q < 4'd4) ? temp_q[cnt_q[1:0]] : rk_q[cnt_q - 4'd4]);
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = READY;
                        round_d = round_q + 4'd1;
                        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            rk_q    <= '{default: '0};
            temp_q  <= '{default: '0};
            cnt_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
`ifdef KEY_EXPAND_REWIND_EN
            shadow_q <= '{default: '0};
`endif
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            temp_q  <= temp_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
`ifdef KEY_EXPAND_REWIND_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign subkey     = rk_q[byte_sel];
    assign round_num  = round_q;
    assign key_ready  = (state_q == READY);
    assign busy       = (state_q == SUBW) || (state_q == XORW);
    assign last_round = (state_q == READY) && (round_q == LAST_RND);

endmodule

// File: tb/tb_key_expand.sv
// tb_key_expand: self-checking bench for key_expand. Expected round keys come
// from a word-level FIPS-197 key expansion whose S-box is derived from the
// GF(2^8) inverse and affine map, plus published test-vector constants.
module tb_key_expand;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       key_load;
    logic [7:0] key_in;
    logic       key_in_valid;
    logic       round_next;
    logic [3:0] byte_sel;
`ifdef KEY_EXPAND_REWIND_EN
    logic       round_rewind;
`endif
    logic [7:0] subkey;
    logic [3:0] round_num;
    logic       key_ready;
    logic       busy;
    logic       last_round;

    key_expand #(.NUM_ROUNDS(10)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .key_load     (key_load),
        .key_in       (key_in),
        .key_in_valid (key_in_valid),
        .round_next   (round_next),
        .byte_sel     (byte_sel),
`ifdef KEY_EXPAND_REWIND_EN
        .round_rewind (round_rewind),
`endif
        .subkey       (subkey),
        .round_num    (round_num),
        .key_ready    (key_ready),
        .busy         (busy),
        .last_round   (last_round)
    );

    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [256];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        logic [127:0] key;
        int           rounds;
        int           gap;
        logic [127:0] exp;
    } vec_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_rk(input logic [127:0] key, input int n);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int r = 0; r < n; r++) begin
            t = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]} ^ {rc, 24'h0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc = xt(rc);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(output logic [127:0] rk);
        for (int b = 0; b < 16; b++) begin
            byte_sel = 4'(b);
            #1;
            rk[127 - 8*b -: 8] = subkey;
        end
    endtask

    task automatic load_key(input logic [127:0] key, input int gap);
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        for (int b = 0; b < 16; b++) begin
            for (int g = 0; g < gap; g++) begin
                key_in_valid = 1'b0;
                key_in       = 8'hxx;
                tick();
            end
            key_in       = key[127 - 8*b -: 8];
            key_in_valid = 1'b1;
            tick();
        end
        key_in_valid = 1'b0;
    endtask

    // Pulse round_next, wait (bounded) for key_ready, return cycles waited
    // and the number of sampled cycles with busy high.
    task automatic step(output int lat, output int nbusy);
        round_next = 1'b1;
        tick();
        round_next = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!key_ready && lat < 40) begin
            if (busy) nbusy++;
            lat++;
            tick();
        end
        if (!key_ready) begin
            bad++;
            total++;
            $display("FAIL step_timeout got=key_ready0 exp=key_ready1");
        end
    endtask

    task automatic run_rounds(input int n);
        int lat, nb;
        for (int r = 0; r < n; r++) begin
            step(lat, nb);
            chk("latency", 128'(lat), 128'd20);
        end
    endtask

    vec_t vecs [4];

    initial begin
        logic [127:0] rk, key2;
        int lat, nb, nr, gp;

        n_rst = 1'b0; key_load = 1'b0; key_in = 8'h00; key_in_valid = 1'b0;
        round_next = 1'b0; byte_sel = 4'd0;
`ifdef KEY_EXPAND_REWIND_EN
        round_rewind = 1'b0;
`endif
        build_sbox();
        #20;
        read_rk(rk);
        chk("reset_rk", rk, '0);
        chk("reset_flags", {round_num, key_ready, busy, last_round}, '0);
        tick();
        n_rst = 1'b1;
        tick();

        // round_next in IDLE is ignored
        round_next = 1'b1; tick(); round_next = 1'b0; tick();
        chk("idle_ignore", {busy, key_ready}, '0);

        vecs[0] = '{128'h0, 1, 0, 128'h62636363626363636263636362636363};
        vecs[1] = '{FIPS_KEY, 1, 0, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{FIPS_KEY, 2, 2, 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3] = '{FIPS_KEY, 10, 0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        for (int v = 0; v < 4; v++) begin
            load_key(vecs[v].key, vecs[v].gap);
            chk("load_ready", {key_ready, busy, round_num}, {1'b1, 1'b0, 4'd0});
            read_rk(rk);
            chk("load_rk", rk, vecs[v].key);
            if (v == 1) begin
                step(lat, nb);
                chk("busy_cycles", 128'(nb), 128'd20);
                chk("latency1", 128'(lat), 128'd20);
            end else begin
                run_rounds(vecs[v].rounds);
            end
            read_rk(rk);
            chk("vec_rk", rk, vecs[v].exp);
            chk("vec_model", rk, ref_rk(vecs[v].key, vecs[v].rounds));
            chk("vec_round", 128'(round_num), 128'(vecs[v].rounds));
            chk("vec_last", 128'(last_round), 128'(vecs[v].rounds == 10));
        end

        // 11th round_next at the last round is ignored
        round_next = 1'b1; tick(); round_next = 1'b0;
        chk("last_nobusy", {busy, key_ready, round_num}, {1'b0, 1'b1, 4'd10});
        tick();
        chk("last_nobusy2", {busy, key_ready, last_round}, {1'b0, 1'b1, 1'b1});
        read_rk(rk);
        chk("last_rk", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // round_next repeated while busy is dropped
        load_key(FIPS_KEY, 0);
        round_next = 1'b1; tick(); round_next = 1'b0;
        repeat (5) tick();
        round_next = 1'b1; tick(); round_next = 1'b0;
        repeat (10) tick();
        round_next = 1'b1; tick(); round_next = 1'b0;
        nb = 0;
        while (!key_ready && nb < 40) begin nb++; tick(); end
        repeat (3) tick();
        read_rk(rk);
        chk("busy_ignore_rk", rk, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("busy_ignore_rnd", 128'(round_num), 128'd1);

        // key_load during XORW j = 7 aborts expansion
        round_next = 1'b1; tick(); round_next = 1'b0;
        repeat (11) tick();
        key_load = 1'b1; tick(); key_load = 1'b0;
        chk("abort_flags", {round_num, key_ready, busy, last_round}, '0);
        key2 = 128'h000102030405060708090a0b0c0d0e0f;
        for (int b = 0; b < 16; b++) begin
            key_in = key2[127 - 8*b -: 8]; key_in_valid = 1'b1; tick();
        end
        key_in_valid = 1'b0;
        read_rk(rk);
        chk("abort_reload", rk, key2);
        chk("abort_ready", {key_ready, round_num}, {1'b1, 4'd0});

        // key_load and round_next together: key_load wins
        key_load = 1'b1; round_next = 1'b1; tick(); key_load = 1'b0; round_next = 1'b0;
        chk("load_wins", {key_ready, busy}, '0);

        // asynchronous reset mid-SUBW
        load_key(FIPS_KEY, 0);
        round_next = 1'b1; tick(); round_next = 1'b0;
        tick();
        n_rst = 1'b0;
        #1;
        read_rk(rk);
        chk("midrst_rk", rk, '0);
        chk("midrst_flags", {round_num, key_ready, busy, last_round}, '0);
        tick();
        n_rst = 1'b1;
        tick();

`ifdef KEY_EXPAND_REWIND_EN
        load_key(FIPS_KEY, 0);
        run_rounds(5);
        round_rewind = 1'b1; tick(); round_rewind = 1'b0;
        read_rk(rk);
        chk("rewind_rk", rk, FIPS_KEY);
        chk("rewind_flags", {key_ready, round_num}, {1'b1, 4'd0});
        run_rounds(1);
        read_rk(rk);
        chk("rewind_r1", rk, 128'ha0fafe1788542cb123a339392a6c7605);
`endif

        // randomized keys, round counts and load gaps against the model
        for (int t = 0; t < 8; t++) begin
            key2 = {$urandom, $urandom, $urandom, $urandom};
            nr   = $urandom_range(0, 10);
            gp   = $urandom_range(0, 2);
            load_key(key2, gp);
            run_rounds(nr);
            read_rk(rk);
            chk("rand_rk", rk, ref_rk(key2, nr));
            chk("rand_state", {round_num, last_round}, {4'(nr), nr == 10});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
